mdu_sequencer: RTL

//  Iterative RV32M multiply/divide unit with its own sequencing FSM, beside the ALU in EX.

---
 rtl/mdu_sequencer_pkg.sv | 34 +++
 rtl/mdu_sequencer_if.sv | 30 +++
 rtl/mdu_iter_core.sv | 62 ++++++
 rtl/mdu_sequencer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mdu_sequencer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mdu_sequencer_pkg : RV32M opcode, funct7 and FSM state encodings |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package mdu_sequencer_pkg;

  localparam logic [2:0] c_f3_mul    = 3'b000;
  localparam logic [2:0] c_f3_mulh   = 3'b001;
  localparam logic [2:0] c_f3_mulhsu = 3'b010;
  localparam logic [2:0] c_f3_mulhu  = 3'b011;
  localparam logic [2:0] c_f3_div    = 3'b100;
  localparam logic [2:0] c_f3_divu   = 3'b101;
  localparam logic [2:0] c_f3_rem    = 3'b110;
  localparam logic [2:0] c_f3_remu   = 3'b111;

  localparam logic [6:0] c_f7_muldiv = 7'b0000001;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_calc  = 2'd1;
  localparam logic [1:0] c_st_fixup = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  function automatic logic f3_signed_a(input logic [2:0] f3);
    return (f3 == c_f3_mulh) || (f3 == c_f3_mulhsu) ||
           (f3 == c_f3_div)  || (f3 == c_f3_rem);
  endfunction

  function automatic logic f3_signed_b(input logic [2:0] f3);
    return (f3 == c_f3_mulh) || (f3 == c_f3_div) || (f3 == c_f3_rem);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_sequencer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mdu_sequencer_if : decoder <-> multiply/divide unit handshake    |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
interface mdu_sequencer_if #(
  parameter int XLEN = 32
);
  logic            i_Start;
  logic            i_Kill;
  logic [6:0]      i_Funct7;
  logic [2:0]      i_Funct3;
  logic [XLEN-1:0] i_OpA;
  logic [XLEN-1:0] i_OpB;
  logic            o_Busy;
  logic            o_Done;
  logic [XLEN-1:0] o_Result;
  logic            o_Illegal;

  modport master (
    output i_Start, i_Kill, i_Funct7, i_Funct3, i_OpA, i_OpB,
    input  o_Busy, o_Done, o_Result, o_Illegal
  );

  modport slave (
    input  i_Start, i_Kill, i_Funct7, i_Funct3, i_OpA, i_OpB,
    output o_Busy, o_Done, o_Result, o_Illegal
  );
endinterface
`default_nettype wire

// File: rtl/mdu_iter_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mdu_iter_core : one shift-add / restoring-subtract step per cycle|
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module mdu_iter_core #(
  parameter int XLEN = 32
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_is_div,
  input  logic [XLEN-1:0]   i_mag_a,
  input  logic [XLEN-1:0]   i_mag_b,
  output logic [2*XLEN-1:0] o_acc
);

  // Multiply: acc = {partial product, multiplier}; operand = multiplicand.
  // Divide:   acc = {remainder, dividend/quotient}; operand = divisor.
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opnd;
  logic              r_is_div;

  logic [XLEN:0]     w_add;
  logic [XLEN:0]     w_shift;
  logic [XLEN:0]     w_trial;
  logic [2*XLEN-1:0] w_mul_next;
  logic [2*XLEN-1:0] w_div_next;

  always_comb begin
    w_add      = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                 (r_acc[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
    w_mul_next = {w_add, r_acc[XLEN-1:1]};
    w_shift    = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    w_trial    = w_shift - {1'b0, r_opnd};
    // A set top bit of the trial difference means the divisor did not fit.
    if (w_trial[XLEN]) begin
      w_div_next = {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
    end else begin
      w_div_next = {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
    end else if (i_load) begin
      r_is_div <= i_is_div;
      r_opnd   <= i_is_div ? i_mag_b : i_mag_a;
      r_acc    <= {{XLEN{1'b0}}, (i_is_div ? i_mag_a : i_mag_b)};
    end else if (i_step) begin
      r_acc    <= r_is_div ? w_div_next : w_mul_next;
    end
  end

  assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/mdu_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mdu_sequencer : iterative RV32M multiply/divide with its own FSM |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic           i_Clk,
  input  logic           i_Rst,
  mdu_sequencer_if.slave mdu
);

  localparam int              c_cnt_w = $clog2(XLEN);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(XLEN-1);
  localparam logic [XLEN-1:0] c_min  = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]         r_state;
  logic [1:0]         w_next;
  logic [c_cnt_w-1:0] r_count;
  logic [2:0]         r_funct3;
  logic               r_sign_a;
  logic               r_sign_b;
  logic               r_fast;
  logic [XLEN-1:0]    r_fast_result;
  logic [XLEN-1:0]    r_result;
  logic               r_illegal;

  logic               w_legal;
  logic               w_accept;
  logic               w_sa;
  logic               w_sb;
  logic               w_div0;
  logic               w_ovf;
  logic               w_fast;
  logic [XLEN-1:0]    w_mag_a;
  logic [XLEN-1:0]    w_mag_b;
  logic [XLEN-1:0]    w_fast_val;
  logic [2*XLEN-1:0]  w_acc;
  logic [2*XLEN-1:0]  w_prod;
  logic [XLEN-1:0]    w_quot;
  logic [XLEN-1:0]    w_rem;
  logic [XLEN-1:0]    w_fix_result;
  logic               w_step;
  logic               w_load;

  always_comb begin
    w_legal  = (mdu.i_Funct7 == c_f7_muldiv);
    w_accept = (r_state == c_st_idle) && mdu.i_Start && !mdu.i_Kill && w_legal;
    w_sa     = f3_signed_a(mdu.i_Funct3) && mdu.i_OpA[XLEN-1];
    w_sb     = f3_signed_b(mdu.i_Funct3) && mdu.i_OpB[XLEN-1];
    w_mag_a  = w_sa ? -mdu.i_OpA : mdu.i_OpA;
    w_mag_b  = w_sb ? -mdu.i_OpB : mdu.i_OpB;
    w_div0   = mdu.i_Funct3[2] && (mdu.i_OpB == '0);
    w_ovf    = mdu.i_Funct3[2] && !mdu.i_Funct3[0] &&
               (mdu.i_OpA == c_min) && (mdu.i_OpB == '1);
    w_fast   = w_div0 || w_ovf;
    if (w_div0) begin
      w_fast_val = mdu.i_Funct3[1] ? mdu.i_OpA : '1;
    end else begin
      w_fast_val = mdu.i_Funct3[1] ? '0 : mdu.i_OpA;
    end
  end

  mdu_iter_core #(
    .XLEN     (XLEN)
  ) u_core (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_is_div (mdu.i_Funct3[2]),
    .i_mag_a  (w_mag_a),
    .i_mag_b  (w_mag_b),
    .o_acc    (w_acc)
  );

  always_comb begin
    w_prod = (r_sign_a ^ r_sign_b) ? -w_acc : w_acc;
    w_quot = (r_sign_a ^ r_sign_b) ? -w_acc[XLEN-1:0] : w_acc[XLEN-1:0];
    w_rem  = r_sign_a ? -w_acc[2*XLEN-1:XLEN] : w_acc[2*XLEN-1:XLEN];
    case (r_funct3)
      c_f3_mul:                         w_fix_result = w_prod[XLEN-1:0];
      c_f3_mulh, c_f3_mulhsu, c_f3_mulhu: w_fix_result = w_prod[2*XLEN-1:XLEN];
      c_f3_div, c_f3_divu:              w_fix_result = w_quot;
      default:                          w_fix_result = w_rem;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next;
    end
  end

  // Fast-path ops spend one cycle in FIXUP so their latency is fixed at two.
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle:  if (w_accept) w_next = w_fast ? c_st_fixup : c_st_calc;
      c_st_calc:  if (r_count == c_last) w_next = c_st_fixup;
      c_st_fixup: w_next = c_st_done;
      default:    w_next = c_st_idle;
    endcase
    if (mdu.i_Kill && (r_state != c_st_idle)) begin
      w_next = c_st_idle;
    end
  end

  always_comb begin
    mdu.o_Busy = (r_state == c_st_calc) || (r_state == c_st_fixup);
    mdu.o_Done = (r_state == c_st_done);
    w_step     = (r_state == c_st_calc) && !mdu.i_Kill;
    w_load     = w_accept;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_count       <= '0;
      r_funct3      <= '0;
      r_sign_a      <= 1'b0;
      r_sign_b      <= 1'b0;
      r_fast        <= 1'b0;
      r_fast_result <= '0;
      r_result      <= '0;
      r_illegal     <= 1'b0;
    end else begin
      r_illegal <= (r_state == c_st_idle) && mdu.i_Start && !mdu.i_Kill && !w_legal;
      if (w_accept) begin
        r_funct3      <= mdu.i_Funct3;
        r_sign_a      <= w_sa;
        r_sign_b      <= w_sb;
        r_fast        <= w_fast;
        r_fast_result <= w_fast_val;
        r_count       <= '0;
      end else if (w_step) begin
        r_count <= r_count + c_cnt_w'(1);
      end
      if ((r_state == c_st_fixup) && !mdu.i_Kill) begin
        r_result <= r_fast ? r_fast_result : w_fix_result;
      end
    end
  end

  assign mdu.o_Result  = r_result;
  assign mdu.o_Illegal = r_illegal;

endmodule
`default_nettype wire
